// File: rtl/clkdiv_pkg.sv
// Shared constants, configuration record and divisor clamp for the clock-enable scheduler.
package clkdiv_pkg;

    localparam int NCH_DEF  = 4;
    localparam int DIVW_DEF = 16;
    localparam int NCH_MAX  = 16;
    localparam int DIV_MAXW = 32;

    typedef struct packed {
        logic [DIV_MAXW-1:0] div;
        logic                en;
    } chan_cfg_t;

    // A divisor of zero has no meaningful period, so it behaves like one.
    function automatic logic [DIV_MAXW-1:0] clamp_div(input logic [DIV_MAXW-1:0] d);
        return (d == '0) ? DIV_MAXW'(1) : d;
    endfunction

endpackage

// File: rtl/clkdiv_sched_if.sv
// Configuration write port and per-channel outputs of the clock-enable scheduler.
interface clkdiv_sched_if #(
    parameter int NCH  = 4,
    parameter int DIVW = 16
) ();

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [CHW-1:0]  cfg_ch;
    logic [DIVW-1:0] cfg_div;
    logic            cfg_en;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  slow_clk;
    logic [NCH-1:0]  active;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_en,
        input  cfg_ready, tick, slow_clk, active
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_en,
        output cfg_ready, tick, slow_clk, active
    );

endinterface

// File: rtl/clkdiv_chan.sv
// One scheduler channel: period counter, current and pending configuration,
// tick pulse and slow clock generation. New settings take effect only at a
// period boundary so consumers never see a runt or stretched period.
module clkdiv_chan #(
    parameter int DIVW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [DIVW-1:0] wr_div,
    input  logic            wr_en,
    output logic            tick,
    output logic            slow_clk,
    output logic            active,
    output logic            pend
);

    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] div_cur;
    logic [DIVW-1:0] div_pend;
    logic            en_cur;
    logic            en_pend;

    logic            at_wrap;
    logic            apply_now;
    logic            apply_pend;
    logic            capture;
    logic [DIVW-1:0] div_next;
    logic [DIVW-1:0] cnt_next;
    logic            en_next;
    logic            tick_next;
    logic            slow_next;

    // Work out next configuration, counter and outputs; writes to a stopped channel or landing on the tick apply at once
    always_comb begin
        at_wrap    = en_cur && (cnt == div_cur - DIVW'(1));
        apply_now  = wr && (!en_cur || at_wrap);
        apply_pend = pend && at_wrap;
        capture    = wr && en_cur && !at_wrap;

        div_next = div_cur;
        en_next  = en_cur;
        if (apply_now) begin
            div_next = wr_div;
            en_next  = wr_en;
        end else if (apply_pend) begin
            div_next = div_pend;
            en_next  = en_pend;
        end

        if (apply_now || apply_pend || !en_cur || at_wrap) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + DIVW'(1);
        end

        tick_next = en_next && (cnt_next == div_next - DIVW'(1));
        slow_next = en_next && (slow_clk ^ tick_next);
    end

    // Counter, live configuration and registered outputs advance together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            div_cur  <= '0;
            en_cur   <= 1'b0;
            tick     <= 1'b0;
            slow_clk <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            div_cur  <= div_next;
            en_cur   <= en_next;
            tick     <= tick_next;
            slow_clk <= slow_next;
        end
    end

    // Park a write to a running channel until its next tick, then release it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= 1'b0;
            div_pend <= '0;
            en_pend  <= 1'b0;
        end else if (capture) begin
            pend     <= 1'b1;
            div_pend <= wr_div;
            en_pend  <= wr_en;
        end else if (apply_pend) begin
            pend     <= 1'b0;
        end
    end

    assign active = en_cur;

endmodule

// File: rtl/clkdiv_sched.sv
// Runtime-programmable clock-enable scheduler: decodes the configuration
// write port onto NCH independent channels and reports per-channel readiness.
module clkdiv_sched
    import clkdiv_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int DIVW = DIVW_DEF
) (
    input logic          clk,
    input logic          rst,
    clkdiv_sched_if.slave bus
);

    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PADW = 2 ** CHW;

    logic [NCH-1:0]  pend;
    logic [NCH-1:0]  wr;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  slow_clk;
    logic [NCH-1:0]  active;
    logic [PADW-1:0] pend_pad;
    logic            ready;
    logic            accept;
    logic [DIVW-1:0] wr_div;

    // Unused channel indices read as never pending, so writes to them are accepted and dropped
    assign pend_pad      = PADW'(pend);
    assign ready         = !pend_pad[bus.cfg_ch];
    assign bus.cfg_ready = ready;
    assign accept        = bus.cfg_valid && ready;
    assign wr_div        = DIVW'(clamp_div(DIV_MAXW'(bus.cfg_div)));

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign wr[i] = accept && (bus.cfg_ch == CHW'(i));

        clkdiv_chan #(
            .DIVW (DIVW)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr[i]),
            .wr_div   (wr_div),
            .wr_en    (bus.cfg_en),
            .tick     (tick[i]),
            .slow_clk (slow_clk[i]),
            .active   (active[i]),
            .pend     (pend[i])
        );
    end

    assign bus.tick     = tick;
    assign bus.slow_clk = slow_clk;
    assign bus.active   = active;

endmodule

// File: tb/tb_clkdiv_sched.sv
// Scoreboard bench for clkdiv_sched: a tick-time reference model predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_clkdiv_sched;
    import clkdiv_pkg::*;

    localparam int NCH  = 5;
    localparam int DIVW = 16;
    localparam int CHW  = $clog2(NCH);

    logic clk = 1'b0;
    logic rst = 1'b0;

    clkdiv_sched_if #(.NCH(NCH), .DIVW(DIVW)) bus ();

    clkdiv_sched #(.NCH(NCH), .DIVW(DIVW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] slow;
        logic [NCH-1:0] active;
        logic           ready;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: absolute cycle of the next tick per channel
    bit        run_m  [NCH];
    int        per_m  [NCH];
    int        next_m [NCH];
    bit        slow_m [NCH];
    bit        pend_m [NCH];
    chan_cfg_t pcfg_m [NCH];
    int        cyc = 0;

    task automatic model_apply(input int c, input int d, input bit e);
        if (e) begin
            run_m[c]  = 1'b1;
            per_m[c]  = d;
            next_m[c] = cyc + d;
        end else begin
            run_m[c]  = 1'b0;
            slow_m[c] = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input bit r, input bit v, input int ch, input int div, input bit en);
        exp_t e;
        bit   t [NCH];
        bit   acc;
        int   d;
        @(posedge clk);
        #1;
        rst           = r;
        bus.cfg_valid = v;
        bus.cfg_ch    = CHW'(ch);
        bus.cfg_div   = DIVW'(div);
        bus.cfg_en    = en;
        e = '0;
        if (r) begin
            for (int c = 0; c < NCH; c++) begin
                run_m[c]  = 1'b0;
                slow_m[c] = 1'b0;
                pend_m[c] = 1'b0;
            end
            e.ready = 1'b1;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                t[c] = run_m[c] && (cyc == next_m[c]);
                if (t[c]) slow_m[c] = !slow_m[c];
                e.tick[c]   = t[c];
                e.slow[c]   = slow_m[c];
                e.active[c] = run_m[c];
            end
            e.ready = (ch >= NCH) ? 1'b1 : !pend_m[ch];
            acc = v && e.ready;
            for (int c = 0; c < NCH; c++) begin
                if (t[c]) begin
                    if (pend_m[c]) begin
                        pend_m[c] = 1'b0;
                        model_apply(c, int'(pcfg_m[c].div), pcfg_m[c].en);
                    end else begin
                        next_m[c] = cyc + per_m[c];
                    end
                end
            end
            if (acc && ch < NCH) begin
                d = (div == 0) ? 1 : div;
                if (!run_m[ch] || t[ch]) begin
                    model_apply(ch, d, en);
                end else begin
                    pend_m[ch] = 1'b1;
                    pcfg_m[ch] = '{div: DIV_MAXW'(d), en: en};
                end
            end
        end
        sb.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 12), 1'($urandom_range(0, 1)));
    endtask

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output("tick",      16'(bus.tick),      16'(e.tick));
            check_output("slow_clk",  16'(bus.slow_clk),  16'(e.slow));
            check_output("active",    16'(bus.active),    16'(e.active));
            check_output("cfg_ready", 16'(bus.cfg_ready), 16'(e.ready));
        end
    end

    initial begin
        if (NCH > NCH_MAX) $fatal(1, "[TB] channel count out of range");
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_div   = '0;
        bus.cfg_en    = 1'b0;

        $display("[TB] reset");
        repeat (3) apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
        idle(2);

        $display("[TB] ch0 start D=5");
        apply_stimulus(1'b0, 1'b1, 0, 5, 1'b1);
        idle(25);

        $display("[TB] ch1 D=4 then D=7 mid-period");
        apply_stimulus(1'b0, 1'b1, 1, 4, 1'b1);
        idle(6);
        apply_stimulus(1'b0, 1'b1, 1, 7, 1'b1);
        idle(25);

        $display("[TB] ch2 D=3 then stop, second write while pending");
        apply_stimulus(1'b0, 1'b1, 2, 3, 1'b1);
        idle(4);
        apply_stimulus(1'b0, 1'b1, 2, 3, 1'b0);
        apply_stimulus(1'b0, 1'b1, 2, 2, 1'b1);
        idle(10);

        $display("[TB] ch3 D=0 and D=1");
        apply_stimulus(1'b0, 1'b1, 3, 0, 1'b1);
        idle(5);
        apply_stimulus(1'b0, 1'b1, 3, 1, 1'b1);
        idle(5);

        $display("[TB] four channels D=2,3,4,5");
        apply_stimulus(1'b0, 1'b1, 0, 2, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1, 3, 1'b1);
        apply_stimulus(1'b0, 1'b1, 2, 4, 1'b1);
        apply_stimulus(1'b0, 1'b1, 3, 5, 1'b1);
        idle(200);

        $display("[TB] reset with ch0 pending");
        apply_stimulus(1'b0, 1'b1, 0, 9, 1'b1);
        apply_stimulus(1'b0, 1'b1, 0, 9, 1'b1);
        idle(1);
        repeat (2) apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
        idle(10);

        $display("[TB] write to out-of-range channel");
        apply_stimulus(1'b0, 1'b1, NCH, 3, 1'b1);
        idle(10);

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
            end else if ($urandom_range(0, 3) == 0) begin
                apply_stimulus(1'b0, 1'b1, $urandom_range(0, 7), $urandom_range(0, 12),
                               $urandom_range(0, 3) != 0);
            end else begin
                idle(1);
            end
        end
        idle(3);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
